// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver with 16x oversampling.
// Two-flop synchroniser on rx, start-edge detection, LSB-first data
// capture and stop-bit check. A good byte updates rx_data and produces a
// one-cycle rx_valid; a low stop bit produces a one-cycle rx_ferr instead.
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes the
// 2-of-3 majority of rx_s at os_cnt 7, 8 and 9 of a boundary-aligned bit,
// decided on the os_cnt=9 tick.
module uart_rx #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BAUD_HZ = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_busy
);

    // Oversample divider, rounded to the nearest integer.
    localparam int unsigned DIV   = (CLK_HZ + 8 * BAUD_HZ) / (16 * BAUD_HZ);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             rxMeta_q, rxS_q, rxSPrev_q;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [3:0]       osCnt_q, osCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxData_q, rxData_d;
    logic             rxValid_q, rxValid_d;
    logic             rxFerr_q, rxFerr_d;
    logic             osTick;
    logic             startEdge;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0]       vote_q, vote_d;
    logic             bitVal;
`endif

    assign osTick    = (state_q != IDLE) && (divCnt_q == DIV_LAST);
    assign startEdge = rxSPrev_q & ~rxS_q;

`ifdef UART_RX_MAJORITY_EN
    assign bitVal = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxS_q) | (vote_q[1] & rxS_q);
`endif

    // Next-state logic: divider, oversample counter, bit capture and strobes.
    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        osCnt_d   = osCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        rxData_d  = rxData_q;
        rxValid_d = 1'b0;
        rxFerr_d  = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        vote_d    = vote_q;
`endif

        if (state_q == IDLE || osTick) begin
            divCnt_d = '0;
        end else begin
            divCnt_d = divCnt_q + 1'b1;
        end

        if (osTick) begin
            osCnt_d = osCnt_q + 4'd1;
        end

`ifdef UART_RX_MAJORITY_EN
        if (osTick && osCnt_q == 4'd7) begin
            vote_d[0] = rxS_q;
        end
        if (osTick && osCnt_q == 4'd8) begin
            vote_d[1] = rxS_q;
        end
`endif

        case (state_q)
            IDLE: begin
                osCnt_d = 4'd0;
                if (startEdge) begin
                    state_d = START;
                end
            end
`ifdef UART_RX_MAJORITY_EN
            START: begin
                if (osTick && osCnt_q == 4'd9 && bitVal) begin
                    state_d = IDLE;
                end else if (osTick && osCnt_q == 4'd15) begin
                    bitIdx_d = 3'd0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (osTick && osCnt_q == 4'd9) begin
                    shift_d = {bitVal, shift_q[7:1]};
                end
                if (osTick && osCnt_q == 4'd15) begin
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (osTick && osCnt_q == 4'd9) begin
                    if (bitVal) begin
                        rxData_d  = shift_q;
                        rxValid_d = 1'b1;
                    end else begin
                        rxFerr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
`else
            START: begin
                if (osTick && osCnt_q == 4'd7) begin
                    if (rxS_q) begin
                        state_d = IDLE;
                    end else begin
                        osCnt_d  = 4'd0;
                        bitIdx_d = 3'd0;
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (osTick && osCnt_q == 4'd15) begin
                    shift_d = {rxS_q, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (osTick && osCnt_q == 4'd15) begin
                    if (rxS_q) begin
                        rxData_d  = shift_q;
                        rxValid_d = 1'b1;
                    end else begin
                        rxFerr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus synchroniser chain; the line idles high so the
    // synchroniser resets to 1 to avoid a false start edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q  <= 1'b1;
            rxS_q     <= 1'b1;
            rxSPrev_q <= 1'b1;
            state_q   <= IDLE;
            divCnt_q  <= '0;
            osCnt_q   <= 4'd0;
            bitIdx_q  <= 3'd0;
            shift_q   <= 8'h00;
            rxData_q  <= 8'h00;
            rxValid_q <= 1'b0;
            rxFerr_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            vote_q    <= 2'b00;
`endif
        end else begin
            rxMeta_q  <= rx;
            rxS_q     <= rxMeta_q;
            rxSPrev_q <= rxS_q;
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            osCnt_q   <= osCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            rxData_q  <= rxData_d;
            rxValid_q <= rxValid_d;
            rxFerr_q  <= rxFerr_d;
`ifdef UART_RX_MAJORITY_EN
            vote_q    <= vote_d;
`endif
        end
    end

    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
    assign rx_ferr  = rxFerr_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at default
// CLK_HZ/BAUD_HZ (432 clk per bit). Frames are built from a plain bit list
// and expectations come from a simple byte-level model of the line.
module tb_uart_rx;

    localparam int BIT_CLK = 432;
`ifdef UART_RX_MAJORITY_EN
    // Decision at the os_cnt=9 tick of the stop bit, plus 3 clk of pipeline.
    localparam int EXP_LAT = 9 * BIT_CLK + 10 * 27 + 3;
`else
    // Mid-point of the stop bit plus 3 clk of pipeline.
    localparam int EXP_LAT = 9 * BIT_CLK + BIT_CLK / 2 + 3;
`endif
    localparam int LAT_TOL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         validCount = 0;
    int         ferrCount  = 0;
    int         lastValidCyc = 0;
    logic [7:0] rxLog[$];
    bit         overlapSeen = 1'b0;
    bit         longPulseSeen = 1'b0;
    logic       prevValid = 1'b0;
    logic       prevFerr  = 1'b0;

    // Reference model: the last correctly framed byte.
    logic [7:0] expLast = 8'h00;

    uart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_busy  (rx_busy)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Free-running cycle counter used to time strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            validCount++;
            lastValidCyc = cyc;
            rxLog.push_back(rx_data);
        end
        if (rx_ferr === 1'b1) ferrCount++;
        if (rx_valid === 1'b1 && rx_ferr === 1'b1) overlapSeen = 1'b1;
        if ((rx_valid === 1'b1 && prevValid === 1'b1) || (rx_ferr === 1'b1 && prevFerr === 1'b1))
            longPulseSeen = 1'b1;
        prevValid = rx_valid;
        prevFerr  = rx_ferr;
    end

    // Drive one 10-bit frame; glitchAt >= 0 inverts the line for one clk at
    // that offset inside every data bit.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                                 input int glitchAt, output int startCyc);
        logic [9:0] fr;
        fr = {stopBit, b, 1'b0};
        startCyc = 0;
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < BIT_CLK; k++) begin
                @(negedge clk);
                rx = fr[f] ^ ((f >= 1) && (f <= 8) && (k == glitchAt));
                if (f == 0 && k == 0) startCyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        int v0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
        total++; if (rx_valid !== 1'b0 || rx_ferr !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes: got valid=%b ferr=%b expected 0/0", rx_valid, rx_ferr); end
        v0 = validCount;
        repeat (2000) @(negedge clk);
        total++; if (validCount != v0) begin bad++; $display("[TB] FAIL idle_no_valid: got %0d strobes expected 0", validCount - v0); end
        total++; if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("[TB] FAIL idle_state: got busy=%b data=%h expected 0/00", rx_busy, rx_data); end
    endtask

    task automatic test_single_frame();
        int v0, f0, n0, s, lat;
        v0 = validCount; f0 = ferrCount; n0 = rxLog.size();
        applyStimulus(8'hA5, 1'b1, -1, s);
        expLast = 8'hA5;
        total++; if (validCount - v0 != 1) begin bad++; $display("[TB] FAIL single_count: got %0d strobes expected 1", validCount - v0); end
        if (rxLog.size() > n0) begin
            total++; if (rxLog[n0] !== 8'hA5) begin bad++; $display("[TB] FAIL single_data: got %h expected a5", rxLog[n0]); end
            lat = lastValidCyc - s;
            total++; if (lat < EXP_LAT - LAT_TOL || lat > EXP_LAT + LAT_TOL) begin bad++; $display("[TB] FAIL single_latency: got %0d clk expected %0d", lat, EXP_LAT); end
        end
        total++; if (ferrCount != f0) begin bad++; $display("[TB] FAIL single_ferr: got %0d expected 0", ferrCount - f0); end
        total++; if (rx_data !== expLast || rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_hold: got data=%h busy=%b expected %h/0", rx_data, rx_busy, expLast); end
    endtask

    task automatic test_back_to_back();
        int v0, n0, s;
        v0 = validCount; n0 = rxLog.size();
        applyStimulus(8'h3C, 1'b1, -1, s);
        applyStimulus(8'hC3, 1'b1, -1, s);
        expLast = 8'hC3;
        total++; if (validCount - v0 != 2) begin bad++; $display("[TB] FAIL b2b_count: got %0d strobes expected 2", validCount - v0); end
        if (rxLog.size() >= n0 + 2) begin
            total++; if (rxLog[n0] !== 8'h3C) begin bad++; $display("[TB] FAIL b2b_first: got %h expected 3c", rxLog[n0]); end
            total++; if (rxLog[n0+1] !== 8'hC3) begin bad++; $display("[TB] FAIL b2b_second: got %h expected c3", rxLog[n0+1]); end
        end
        total++; if (rx_data !== expLast) begin bad++; $display("[TB] FAIL b2b_data: got %h expected %h", rx_data, expLast); end
    endtask

    task automatic test_framing_error();
        int v0, f0, n0, s;
        logic [7:0] r;
        v0 = validCount; f0 = ferrCount;
        applyStimulus(8'h55, 1'b0, -1, s);
        repeat (5000) @(negedge clk);
        total++; if (ferrCount - f0 != 1) begin bad++; $display("[TB] FAIL ferr_count: got %0d expected 1", ferrCount - f0); end
        total++; if (validCount != v0) begin bad++; $display("[TB] FAIL ferr_no_valid: got %0d strobes expected 0", validCount - v0); end
        total++; if (rx_data !== expLast) begin bad++; $display("[TB] FAIL ferr_data_kept: got %h expected %h", rx_data, expLast); end
        rx = 1'b1;
        repeat (500) @(negedge clk);
        r = 8'($urandom_range(0, 255));
        n0 = rxLog.size(); f0 = ferrCount;
        applyStimulus(r, 1'b1, -1, s);
        expLast = r;
        total++; if (rxLog.size() != n0 + 1 || rx_data !== expLast || ferrCount != f0) begin bad++; $display("[TB] FAIL ferr_recover: got data=%h strobes=%0d expected %h and 1", rx_data, rxLog.size() - n0, expLast); end
    endtask

    task automatic test_glitch();
        int v0, f0, n0, s;
        v0 = validCount; f0 = ferrCount;
        @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy: got %b expected 0", rx_busy); end
        total++; if (validCount != v0 || ferrCount != f0) begin bad++; $display("[TB] FAIL glitch_strobe: got valid=%0d ferr=%0d expected 0/0", validCount - v0, ferrCount - f0); end
        n0 = rxLog.size();
        applyStimulus(8'h81, 1'b1, -1, s);
        expLast = 8'h81;
        total++; if (rxLog.size() != n0 + 1 || rx_data !== 8'h81) begin bad++; $display("[TB] FAIL glitch_next: got data=%h strobes=%0d expected 81 and 1", rx_data, rxLog.size() - n0); end
    endtask

    task automatic test_reset_midframe();
        int v0, f0, n0, s;
        logic [9:0] fr;
        fr = {1'b1, 8'hFF, 1'b0};
        v0 = validCount; f0 = ferrCount;
        for (int k = 0; k < 5 * BIT_CLK + 200; k++) begin
            @(negedge clk);
            rx = fr[k / BIT_CLK];
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expLast = 8'h00;
        total++; if (rx_busy !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_clear: got busy=%b data=%h valid=%b expected 0/00/0", rx_busy, rx_data, rx_valid); end
        repeat (5 * BIT_CLK + 500) @(negedge clk);
        total++; if (validCount != v0 || ferrCount != f0) begin bad++; $display("[TB] FAIL midreset_strobe: got valid=%0d ferr=%0d expected 0/0", validCount - v0, ferrCount - f0); end
        n0 = rxLog.size();
        applyStimulus(8'h42, 1'b1, 243, s);
        expLast = 8'h42;
        total++; if (rxLog.size() != n0 + 1 || rx_data !== 8'h42) begin bad++; $display("[TB] FAIL midreset_next: got data=%h strobes=%0d expected 42 and 1", rx_data, rxLog.size() - n0); end
    endtask

    task automatic test_random_frames();
        int n0, s, lat;
        logic [7:0] r;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            r = 8'($urandom_range(0, 255));
            n0 = rxLog.size();
            applyStimulus(r, 1'b1, -1, s);
            expLast = r;
            total++;
            if (rxLog.size() != n0 + 1) begin
                bad++; $display("[TB] FAIL random_count[%0d]: got %0d strobes expected 1", i, rxLog.size() - n0);
            end else if (rxLog[n0] !== r) begin
                bad++; $display("[TB] FAIL random_data[%0d]: got %h expected %h", i, rxLog[n0], r);
            end
            lat = lastValidCyc - s;
            total++; if (lat < EXP_LAT - LAT_TOL || lat > EXP_LAT + LAT_TOL) begin bad++; $display("[TB] FAIL random_latency[%0d]: got %0d clk expected %0d", i, lat, EXP_LAT); end
        end
    endtask

    task automatic test_strobe_shape();
        total++; if (overlapSeen) begin bad++; $display("[TB] FAIL strobe_overlap: got 1 expected 0"); end
        total++; if (longPulseSeen) begin bad++; $display("[TB] FAIL strobe_width: got multi-cycle pulse expected single cycle"); end
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] uart_rx bench start");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_reset_midframe();
        test_random_frames();
        test_strobe_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
